sram_line_en_dualport: RTL and testbench

- True dual-port, single-clock synchronous SRAM with word-wide ("line") write enables and no byte lanes.
- Each of two independent ports (A, B) can read or write any word every cycle.
- Used as shared storage between a bus-side client (port A) and a hardware engine (port B), e.g. message-queue buffers.
- Each port corresponds to one generic_sram_line_en_if instance (sram modport), flattened to discrete signals below.

---
 rtl/sram_line_en_dualport.sv | 79 +++++++
 tb/tb_sram_line_en_dualport.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_line_en_dualport.sv
// True dual-port, single-clock synchronous SRAM with whole-word write enables.
// Port A is the bus-side client, port B the hardware engine. Both ports are
// read-first, and port A wins when both ports write the same word in a cycle.
// Read data is registered (latency 1) and cleared asynchronously by reset.
module sram_line_en_dualport #(
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic [MEM_ADDR_BITS-1:0] a_addr,
    input  logic [MEM_DATA_BITS-1:0] a_write_data,
    input  logic                     a_write_en,
    input  logic                     a_read_en,
    output logic [MEM_DATA_BITS-1:0] a_read_data,

    input  logic [MEM_ADDR_BITS-1:0] b_addr,
    input  logic [MEM_DATA_BITS-1:0] b_write_data,
    input  logic                     b_write_en,
    input  logic                     b_read_en,
    output logic [MEM_DATA_BITS-1:0] b_read_data
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    // Storage array; maps onto inferred block RAM.
    logic [MEM_DATA_BITS-1:0] mem_q [MEM_DEPTH];

    // Registered read data, one register per port.
    logic [MEM_DATA_BITS-1:0] a_read_data_q;
    logic [MEM_DATA_BITS-1:0] b_read_data_q;

    // Effective write strobes: nothing is stored while reset is high, and a
    // port-B write to the same word port A is writing is dropped.
    logic a_wr_ok;
    logic b_wr_ok;
    logic same_addr;

    assign same_addr = (a_addr == b_addr);
    assign a_wr_ok   = a_write_en && !i_rst;
    assign b_wr_ok   = b_write_en && !i_rst && !(a_write_en && same_addr);

    // Array write for both ports.
    // NOTE: the array has no reset branch; a reset on every word would stop
    // the tools from mapping it onto block RAM and cost a huge clear network.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking writes make any read of mem_q in this same edge
        // see the pre-write contents, which is exactly read-first behaviour.
        if (b_wr_ok) begin
            mem_q[b_addr] <= b_write_data;
        end
        if (a_wr_ok) begin
            mem_q[a_addr] <= a_write_data;
        end
    end

    // Port A registered read; holds when not enabled, cleared by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_read_data_q <= '0;
        end else if (a_read_en) begin
            a_read_data_q <= mem_q[a_addr];
        end
    end

    // Port B registered read; holds when not enabled, cleared by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            b_read_data_q <= '0;
        end else if (b_read_en) begin
            b_read_data_q <= mem_q[b_addr];
        end
    end

    assign a_read_data = a_read_data_q;
    assign b_read_data = b_read_data_q;

endmodule

// File: tb/tb_sram_line_en_dualport.sv
// Directed testbench for sram_line_en_dualport. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, so each comparison
// sees the result of the edge just taken.
module tb_sram_line_en_dualport;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          i_clk;
    logic          i_rst;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_write_data;
    logic          a_write_en;
    logic          a_read_en;
    logic [DW-1:0] a_read_data;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_write_data;
    logic          b_write_en;
    logic          b_read_en;
    logic [DW-1:0] b_read_data;

    int checks;
    int errors;

    sram_line_en_dualport #(
        .MEM_ADDR_BITS(AW),
        .MEM_DATA_BITS(DW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .a_addr      (a_addr),
        .a_write_data(a_write_data),
        .a_write_en  (a_write_en),
        .a_read_en   (a_read_en),
        .a_read_data (a_read_data),
        .b_addr      (b_addr),
        .b_write_data(b_write_data),
        .b_write_en  (b_write_en),
        .b_read_en   (b_read_en),
        .b_read_data (b_read_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drop every enable on both ports.
    task automatic idle();
        a_write_en = 1'b0;
        a_read_en  = 1'b0;
        b_write_en = 1'b0;
        b_read_en  = 1'b0;
    endtask

    task automatic a_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_addr       = addr;
        a_write_data = data;
        a_write_en   = 1'b1;
    endtask

    task automatic b_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        b_addr       = addr;
        b_write_data = data;
        b_write_en   = 1'b1;
    endtask

    task automatic a_rd(input logic [AW-1:0] addr);
        a_addr    = addr;
        a_read_en = 1'b1;
    endtask

    task automatic b_rd(input logic [AW-1:0] addr);
        b_addr    = addr;
        b_read_en = 1'b1;
    endtask

    task automatic test_reset();
        // Seed addresses 5 and 6 and load both read registers with non-zero data.
        idle();
        a_wr(10'd5, 32'h5A5A_5A5A);
        b_wr(10'd6, 32'h6666_6666);
        tick();
        idle();
        a_rd(10'd5);
        b_rd(10'd6);
        tick();
        checks++;
        if (a_read_data !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL reset_seed_a: got %h expected %h", a_read_data, 32'h5A5A_5A5A);
        end
        checks++;
        if (b_read_data !== 32'h6666_6666) begin
            errors++;
            $display("FAIL reset_seed_b: got %h expected %h", b_read_data, 32'h6666_6666);
        end
        // Assert reset between edges: outputs must clear without a clock.
        idle();
        i_rst = 1'b1;
        #1;
        checks++;
        if (a_read_data !== '0 || b_read_data !== '0) begin
            errors++;
            $display("FAIL reset_async: got a=%h b=%h expected 0", a_read_data, b_read_data);
        end
        // Reads and writes presented during reset are ignored.
        a_rd(10'd5);
        b_rd(10'd6);
        a_wr(10'd5, 32'hFFFF_FFFF);
        b_wr(10'd6, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_read_data !== '0 || b_read_data !== '0) begin
                errors++;
                $display("FAIL reset_hold_%0d: got a=%h b=%h expected 0", i, a_read_data, b_read_data);
            end
        end
        i_rst = 1'b0;
        idle();
        a_rd(10'd5);
        b_rd(10'd6);
        tick();
        checks++;
        if (a_read_data !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL reset_no_write_a: got %h expected %h", a_read_data, 32'h5A5A_5A5A);
        end
        checks++;
        if (b_read_data !== 32'h6666_6666) begin
            errors++;
            $display("FAIL reset_no_write_b: got %h expected %h", b_read_data, 32'h6666_6666);
        end
        idle();
    endtask

    task automatic test_basic();
        idle();
        a_wr(10'h010, 32'hDEAD_BEEF);
        tick();
        // Read enable was low on the write cycle, so the old value must hold.
        checks++;
        if (a_read_data !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL basic_hold_on_write: got %h expected %h", a_read_data, 32'h5A5A_5A5A);
        end
        idle();
        a_rd(10'h010);
        tick();
        checks++;
        if (a_read_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_latency: got %h expected %h", a_read_data, 32'hDEAD_BEEF);
        end
        // Move the address away with read enable low: data must hold.
        idle();
        a_addr = 10'd5;
        tick();
        tick();
        checks++;
        if (a_read_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_hold: got %h expected %h", a_read_data, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_cross_port();
        idle();
        a_wr(10'h3FF, 32'h1234_5678);
        tick();
        idle();
        b_rd(10'h3FF);
        tick();
        checks++;
        if (b_read_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL cross_a_to_b: got %h expected %h", b_read_data, 32'h1234_5678);
        end
        idle();
        b_wr(10'h000, 32'hCAFE_F00D);
        tick();
        idle();
        a_rd(10'h000);
        tick();
        checks++;
        if (a_read_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL cross_b_to_a: got %h expected %h", a_read_data, 32'hCAFE_F00D);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        a_wr(10'd7, 32'h0000_0001);
        b_wr(10'd8, 32'h0000_0002);
        tick();
        idle();
        a_rd(10'd8);
        b_rd(10'd7);
        tick();
        checks++;
        if (a_read_data !== 32'h0000_0002) begin
            errors++;
            $display("FAIL indep_a_reads_8: got %h expected %h", a_read_data, 32'h0000_0002);
        end
        checks++;
        if (b_read_data !== 32'h0000_0001) begin
            errors++;
            $display("FAIL indep_b_reads_7: got %h expected %h", b_read_data, 32'h0000_0001);
        end
        idle();
    endtask

    task automatic test_collision_rw();
        idle();
        a_wr(10'd4, 32'h0000_00AA);
        tick();
        // A writes while B reads the same word: B sees the old value.
        idle();
        a_wr(10'd4, 32'h0000_00BB);
        b_rd(10'd4);
        tick();
        checks++;
        if (b_read_data !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL coll_b_reads_old: got %h expected %h", b_read_data, 32'h0000_00AA);
        end
        idle();
        a_rd(10'd4);
        b_rd(10'd4);
        tick();
        checks++;
        if (a_read_data !== 32'h0000_00BB || b_read_data !== 32'h0000_00BB) begin
            errors++;
            $display("FAIL coll_a_write_lands: got a=%h b=%h expected %h", a_read_data, b_read_data, 32'h0000_00BB);
        end
        // Mirror case: B writes while A reads the same word.
        idle();
        b_wr(10'd4, 32'h0000_00CC);
        a_rd(10'd4);
        tick();
        checks++;
        if (a_read_data !== 32'h0000_00BB) begin
            errors++;
            $display("FAIL coll_a_reads_old: got %h expected %h", a_read_data, 32'h0000_00BB);
        end
        idle();
        a_rd(10'd4);
        tick();
        checks++;
        if (a_read_data !== 32'h0000_00CC) begin
            errors++;
            $display("FAIL coll_b_write_lands: got %h expected %h", a_read_data, 32'h0000_00CC);
        end
        idle();
    endtask

    task automatic test_collision_ww();
        idle();
        a_wr(10'd9, 32'h0000_0011);
        b_wr(10'd9, 32'h0000_0022);
        tick();
        idle();
        a_rd(10'd9);
        b_rd(10'd9);
        tick();
        checks++;
        if (a_read_data !== 32'h0000_0011 || b_read_data !== 32'h0000_0011) begin
            errors++;
            $display("FAIL coll_ww_a_wins: got a=%h b=%h expected %h", a_read_data, b_read_data, 32'h0000_0011);
        end
        idle();
    endtask

    task automatic test_read_first();
        idle();
        a_wr(10'd3, 32'h0000_0055);
        tick();
        idle();
        a_wr(10'd3, 32'h0000_0066);
        a_read_en = 1'b1;
        tick();
        checks++;
        if (a_read_data !== 32'h0000_0055) begin
            errors++;
            $display("FAIL rf_a_old: got %h expected %h", a_read_data, 32'h0000_0055);
        end
        idle();
        a_rd(10'd3);
        tick();
        checks++;
        if (a_read_data !== 32'h0000_0066) begin
            errors++;
            $display("FAIL rf_a_new: got %h expected %h", a_read_data, 32'h0000_0066);
        end
        // Same check on port B.
        idle();
        b_wr(10'd3, 32'h0000_0077);
        b_read_en = 1'b1;
        tick();
        checks++;
        if (b_read_data !== 32'h0000_0066) begin
            errors++;
            $display("FAIL rf_b_old: got %h expected %h", b_read_data, 32'h0000_0066);
        end
        idle();
        b_rd(10'd3);
        tick();
        checks++;
        if (b_read_data !== 32'h0000_0077) begin
            errors++;
            $display("FAIL rf_b_new: got %h expected %h", b_read_data, 32'h0000_0077);
        end
        idle();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        i_rst        = 1'b1;
        a_addr       = '0;
        a_write_data = '0;
        b_addr       = '0;
        b_write_data = '0;
        idle();
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        test_reset();
        test_basic();
        test_cross_port();
        test_back_to_back();
        test_collision_rw();
        test_collision_ww();
        test_read_first();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
